// File: rtl/rx_frame_fifo_if.sv
// ---------------------------------------------------------------------------
// rx_frame_fifo_if
// Groups the frame input, host read port and status outputs of rx_frame_fifo.
//   master : drives frame_in/frame_valid/rd_en/clr_err, observes status
//   slave  : the FIFO itself
// Signals:
//   frame_in[9:0]   received frame (bit0 start, bits8:1 data, bit9 stop)
//   frame_valid     frame_in holds a completed frame (may be held high)
//   rd_en           pop the head entry
//   clr_err         clear sticky frame_err / overrun
//   rd_data[7:0]    head-of-FIFO byte, 0 when empty
//   empty, full     occupancy flags
//   count[CW-1:0]   occupancy 0..DEPTH
//   frame_err       sticky bad start/stop bit seen
//   overrun         sticky good frame dropped while full
//   good_frames     saturating count of accepted frames
// ---------------------------------------------------------------------------
interface rx_frame_fifo_if #(
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH) + 1
);
    logic [9:0]    frame_in;
    logic          frame_valid;
    logic          rd_en;
    logic          clr_err;
    logic [7:0]    rd_data;
    logic          empty;
    logic          full;
    logic [CW-1:0] count;
    logic          frame_err;
    logic          overrun;
    logic [7:0]    good_frames;

    modport master (
        output frame_in, frame_valid, rd_en, clr_err,
        input  rd_data, empty, full, count, frame_err, overrun, good_frames
    );

    modport slave (
        input  frame_in, frame_valid, rd_en, clr_err,
        output rd_data, empty, full, count, frame_err, overrun, good_frames
    );
endinterface

// File: rtl/rx_frame_fifo.sv
// ---------------------------------------------------------------------------
// rx_frame_fifo
// Checks framing of completed UART frames, queues the data byte in a
// first-word-fall-through FIFO and reports framing errors, overruns and a
// saturating count of accepted frames. Runs on the system clock.
// Ports:
//   Clk  system clock, rising edge
//   Rst  synchronous active-low reset
//   bus  rx_frame_fifo_if slave modport (frame input, read port, status)
// ---------------------------------------------------------------------------
module rx_frame_fifo #(
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic           Clk,
    input  logic           Rst,
    rx_frame_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_fv_q;
    logic          r_frame_err;
    logic          r_overrun;
    logic [7:0]    r_good_frames;

    logic          w_strobe;
    logic          w_good;
    logic          w_empty;
    logic          w_full;
    logic          w_push;
    logic          w_pop;

    assign w_strobe = bus.frame_valid & ~r_fv_q;
    assign w_good   = ~bus.frame_in[0] & bus.frame_in[9];
    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == CW'(DEPTH));
    // A pop in the same cycle frees the slot, so a push at full is still legal.
    assign w_push   = w_strobe & w_good & (~w_full | bus.rd_en);
    assign w_pop    = bus.rd_en & ~w_empty;

    // The edge detector tracks frame_valid even during reset, so a frame_valid
    // already high at reset release is not mistaken for a new frame.
    always_ff @(posedge Clk) begin
        r_fv_q <= bus.frame_valid;
    end

    // Storage carries no reset; validity is tracked by the pointers and count.
    always_ff @(posedge Clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.frame_in[8:1];
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_frame_err   <= 1'b0;
            r_overrun     <= 1'b0;
            r_good_frames <= 8'h00;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            // Set beats clear when both happen in the same cycle.
            if (w_strobe && !w_good) begin
                r_frame_err <= 1'b1;
            end else if (bus.clr_err) begin
                r_frame_err <= 1'b0;
            end

            if (w_strobe && w_good && w_full && !bus.rd_en) begin
                r_overrun <= 1'b1;
            end else if (bus.clr_err) begin
                r_overrun <= 1'b0;
            end

            if (w_push && (r_good_frames != 8'hFF)) begin
                r_good_frames <= r_good_frames + 1'b1;
            end
        end
    end

    assign bus.rd_data     = w_empty ? 8'h00 : r_mem[r_rd_ptr];
    assign bus.empty       = w_empty;
    assign bus.full        = w_full;
    assign bus.count       = r_count;
    assign bus.frame_err   = r_frame_err;
    assign bus.overrun     = r_overrun;
    assign bus.good_frames = r_good_frames;
endmodule

// File: tb/tb_rx_frame_fifo.sv
// ---------------------------------------------------------------------------
// tb_rx_frame_fifo
// Randomized and directed stimulus for rx_frame_fifo, checked every cycle
// against a queue-based reference model, plus fixed expected values for the
// directed scenarios.
// ---------------------------------------------------------------------------
module tb_rx_frame_fifo;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic Clk = 1'b0;
    logic Rst = 1'b0;

    rx_frame_fifo_if #(.DEPTH(DEPTH), .CW(CW)) bus ();

    rx_frame_fifo #(.DEPTH(DEPTH), .CW(CW)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus.slave)
    );

    always #5 Clk = ~Clk;

    int n_asserts = 0;
    int n_fail    = 0;

    // Reference model state
    logic [7:0] m_q[$];
    bit         m_fv_prev = 1'b0;
    bit         m_ferr    = 1'b0;
    bit         m_ovr     = 1'b0;
    int         m_good    = 0;

    task automatic chk(input string tag, input int act, input int exp);
        n_asserts++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [9:0] mk_frame(input logic [7:0] b);
        return {1'b1, b, 1'b0};
    endfunction

    // Applies the rules of one clock edge to the model using the inputs that
    // were presented for that edge.
    task automatic model_step();
        bit strobe, good, do_push, do_pop, set_err, set_ovr;
        if (!Rst) begin
            m_q.delete();
            m_ferr = 1'b0;
            m_ovr  = 1'b0;
            m_good = 0;
        end else begin
            strobe  = bus.frame_valid && !m_fv_prev;
            good    = (bus.frame_in[0] == 1'b0) && (bus.frame_in[9] == 1'b1);
            do_pop  = bus.rd_en && (m_q.size() > 0);
            do_push = strobe && good && ((m_q.size() < DEPTH) || bus.rd_en);
            set_err = strobe && !good;
            set_ovr = strobe && good && (m_q.size() == DEPTH) && !bus.rd_en;
            if (set_err)          m_ferr = 1'b1;
            else if (bus.clr_err) m_ferr = 1'b0;
            if (set_ovr)          m_ovr = 1'b1;
            else if (bus.clr_err) m_ovr = 1'b0;
            if (do_pop) void'(m_q.pop_front());
            if (do_push) begin
                m_q.push_back(bus.frame_in[8:1]);
                if (m_good < 255) m_good++;
            end
        end
        m_fv_prev = bus.frame_valid;
    endtask

    task automatic check_model();
        chk("count",     int'(bus.count),       m_q.size());
        chk("empty",     int'(bus.empty),       int'(m_q.size() == 0));
        chk("full",      int'(bus.full),        int'(m_q.size() == DEPTH));
        chk("rd_data",   int'(bus.rd_data),     (m_q.size() == 0) ? 0 : int'(m_q[0]));
        chk("frame_err", int'(bus.frame_err),   int'(m_ferr));
        chk("overrun",   int'(bus.overrun),     int'(m_ovr));
        chk("good",      int'(bus.good_frames), m_good);
    endtask

    // Inputs change only at the falling edge; outputs are checked there too.
    task automatic tick();
        @(posedge Clk);
        model_step();
        @(negedge Clk);
        check_model();
    endtask

    task automatic send_frame(input logic [9:0] f, input int hold);
        bus.frame_in    = f;
        bus.frame_valid = 1'b1;
        repeat (hold) tick();
        bus.frame_valid = 1'b0;
        tick();
    endtask

    task automatic pop_one();
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
    endtask

    logic [7:0] last_pop;

    initial begin
        bus.frame_in    = '0;
        bus.frame_valid = 1'b0;
        bus.rd_en       = 1'b0;
        bus.clr_err     = 1'b0;

        // Reset state
        Rst = 1'b0;
        tick();
        tick();
        chk("rst_empty", int'(bus.empty), 1);
        chk("rst_full",  int'(bus.full), 0);
        chk("rst_count", int'(bus.count), 0);
        chk("rst_rd",    int'(bus.rd_data), 0);
        Rst = 1'b1;
        tick();

        // One push despite frame_valid held for three cycles
        send_frame(10'b1_10100101_0, 3);
        chk("a5_count", int'(bus.count), 1);
        chk("a5_data",  int'(bus.rd_data), 8'hA5);
        chk("a5_good",  int'(bus.good_frames), 1);
        chk("a5_empty", int'(bus.empty), 0);
        pop_one();

        // Bad start bit, then bad stop bit
        send_frame(10'h3FF, 1);
        send_frame(10'h0AA, 1);
        chk("bad_count", int'(bus.count), 0);
        chk("bad_ferr",  int'(bus.frame_err), 1);
        bus.clr_err = 1'b1;
        tick();
        bus.clr_err = 1'b0;
        chk("clr_ferr", int'(bus.frame_err), 0);

        // Fill, overrun, drain in order
        for (int i = 1; i <= 8; i++) send_frame(mk_frame(8'(i)), 1);
        chk("fill_full",  int'(bus.full), 1);
        chk("fill_count", int'(bus.count), 8);
        send_frame(mk_frame(8'h09), 1);
        chk("ovr_set",   int'(bus.overrun), 1);
        chk("ovr_count", int'(bus.count), 8);
        for (int i = 1; i <= 8; i++) begin
            chk("pop_order", int'(bus.rd_data), i);
            pop_one();
        end
        chk("drain_empty", int'(bus.empty), 1);
        chk("drain_rd",    int'(bus.rd_data), 0);
        bus.clr_err = 1'b1;
        tick();
        bus.clr_err = 1'b0;
        chk("clr_ovr", int'(bus.overrun), 0);

        // Simultaneous push and pop while full
        for (int i = 0; i < 8; i++) send_frame(mk_frame(8'(8'h10 + i)), 1);
        bus.frame_in    = mk_frame(8'hC3);
        bus.frame_valid = 1'b1;
        bus.rd_en       = 1'b1;
        tick();
        bus.frame_valid = 1'b0;
        bus.rd_en       = 1'b0;
        tick();
        chk("pp_count", int'(bus.count), 8);
        chk("pp_ovr",   int'(bus.overrun), 0);
        last_pop = 8'h00;
        for (int i = 0; i < 8; i++) begin
            last_pop = bus.rd_data;
            pop_one();
        end
        chk("pp_last",  int'(last_pop), 8'hC3);
        chk("pp_empty", int'(bus.empty), 1);

        // 300 frames with continuous popping: saturation and wrap
        for (int i = 0; i < 300; i++) begin
            bus.frame_in    = mk_frame(8'($urandom));
            bus.frame_valid = 1'b1;
            bus.rd_en       = 1'b1;
            tick();
            bus.frame_valid = 1'b0;
            tick();
        end
        bus.rd_en = 1'b0;
        chk("sat_good", int'(bus.good_frames), 255);

        // Randomized traffic including bad frames and clears
        for (int i = 0; i < 400; i++) begin
            logic [9:0] f;
            f = 10'($urandom);
            if ($urandom_range(0, 3) != 0) begin
                f[0] = 1'b0;
                f[9] = 1'b1;
            end
            bus.frame_in    = f;
            bus.frame_valid = ($urandom_range(0, 2) == 0);
            bus.rd_en       = ($urandom_range(0, 2) == 0);
            bus.clr_err     = ($urandom_range(0, 15) == 0);
            tick();
        end
        bus.frame_valid = 1'b0;
        bus.rd_en       = 1'b0;
        bus.clr_err     = 1'b1;
        tick();
        bus.clr_err = 1'b0;
        for (int i = 0; i <= DEPTH; i++) pop_one();
        chk("rand_drained", int'(bus.empty), 1);

        // Reset with five entries and overrun pending
        for (int i = 0; i < 8; i++) send_frame(mk_frame(8'(8'h20 + i)), 1);
        send_frame(mk_frame(8'h2F), 1);
        repeat (3) pop_one();
        chk("pre_rst_count", int'(bus.count), 5);
        chk("pre_rst_ovr",   int'(bus.overrun), 1);
        bus.frame_in    = mk_frame(8'h5A);
        bus.frame_valid = 1'b1;
        Rst = 1'b0;
        tick();
        chk("mid_rst_count", int'(bus.count), 0);
        chk("mid_rst_empty", int'(bus.empty), 1);
        chk("mid_rst_ovr",   int'(bus.overrun), 0);
        chk("mid_rst_good",  int'(bus.good_frames), 0);
        chk("mid_rst_rd",    int'(bus.rd_data), 0);
        Rst = 1'b1;
        repeat (3) tick();
        chk("held_fv_count", int'(bus.count), 0);
        bus.frame_valid = 1'b0;
        tick();
        bus.frame_valid = 1'b1;
        tick();
        chk("retoggle_count", int'(bus.count), 1);
        chk("retoggle_data",  int'(bus.rd_data), 8'h5A);
        bus.frame_valid = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
